// File: rtl/bus_tx_driver.sv
// Bus driving end: buffers producer words in a FIFO and emits them one beat
// at a time on a valid-only bus, with a fixed idle gap after every beat.
module bus_tx_driver #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int GAP    = 0,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     bus_valid,
  output logic [DATA_W-1:0]        bus_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         sent_count,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LD = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [GW-1:0]     gap_cnt;
  logic [GW-1:0]     gap_nxt;
  logic              push;
  logic              pop;
  logic              can_go;
  logic              bv_nxt;
  logic [DATA_W-1:0] bd_nxt;

  assign in_ready = (fifo_level != FULL) & ~rst;
  assign push     = in_valid & in_ready;
  assign can_go   = en & (fifo_level != '0);
  assign busy     = (state != S_IDLE) | (fifo_level != '0);

  // every entry into SEND pops the head word onto the bus
  assign pop = (state_nxt == S_SEND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (can_go) state_nxt = S_SEND;
      end
      S_SEND: begin
        if (GAP > 0)     state_nxt = S_GAP;
        else if (can_go) state_nxt = S_SEND;
        else             state_nxt = S_IDLE;
      end
      S_GAP: begin
        if (gap_cnt == '0)
          state_nxt = can_go ? S_SEND : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bv_nxt  = pop;
    bd_nxt  = pop ? mem[rd_ptr] : '0;
    gap_nxt = gap_cnt;
    if (state == S_SEND)
      gap_nxt = GAP_LD;
    else if (state == S_GAP && gap_cnt != '0)
      gap_nxt = gap_cnt - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_valid  <= 1'b0;
      bus_data   <= '0;
      gap_cnt    <= '0;
      sent_count <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      bus_valid  <= bv_nxt;
      bus_data   <= bd_nxt;
      gap_cnt    <= gap_nxt;
      sent_count <= sent_count + {{(CNT_W-1){1'b0}}, pop};
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // storage needs no reset: pointers and level define what is valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_bus_tx_driver.sv
// Bench for bus_tx_driver: GAP=0 and GAP=2 instances share stimulus and are
// compared each cycle against a queue-based beat-scheduling model.
module tb_bus_tx_driver;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        iv = 1'b0;
  logic [15:0] id = '0;

  logic        rdy0, bv0, busy0;
  logic [15:0] bd0, cnt0;
  logic [2:0]  lvl0;
  logic        rdy2, bv2, busy2;
  logic [15:0] bd2, cnt2;
  logic [2:0]  lvl2;

  bus_tx_driver #(.DATA_W(16), .DEPTH(DEPTH), .GAP(0), .CNT_W(16)) u_d0 (
    .clk(clk), .rst(rst), .en(en), .in_valid(iv), .in_ready(rdy0),
    .in_data(id), .bus_valid(bv0), .bus_data(bd0), .fifo_level(lvl0),
    .sent_count(cnt0), .busy(busy0)
  );

  bus_tx_driver #(.DATA_W(16), .DEPTH(DEPTH), .GAP(2), .CNT_W(16)) u_d2 (
    .clk(clk), .rst(rst), .en(en), .in_valid(iv), .in_ready(rdy2),
    .in_data(id), .bus_valid(bv2), .bus_data(bd2), .fifo_level(lvl2),
    .sent_count(cnt2), .busy(busy2)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nbad = 0;

  logic [15:0] q0[$];
  logic [15:0] q2[$];
  int          need[2];
  logic [15:0] mcnt[2];
  logic        ebv[2];
  logic [15:0] ebd[2];
  logic        ebusy[2];

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q2.size();
  endfunction

  function automatic logic [15:0] qpop(input int i);
    if (i == 0) return q0.pop_front();
    return q2.pop_front();
  endfunction

  function automatic void qpush(input int i, input logic [15:0] d);
    if (i == 0) q0.push_back(d);
    else        q2.push_back(d);
  endfunction

  function automatic void model_clear();
    q0.delete();
    q2.delete();
    for (int i = 0; i < 2; i++) begin
      need[i]  = 0;
      mcnt[i]  = '0;
      ebv[i]   = 1'b0;
      ebd[i]   = '0;
      ebusy[i] = 1'b0;
    end
  endfunction

  // one clock edge: a beat starts when enabled, data is buffered, and at
  // least gap idle cycles have elapsed since the previous beat
  function automatic void model_edge(input int i, input int gap);
    int          prev;
    bit          beat;
    bit          rdy;
    logic [15:0] w;
    rdy  = (qsize(i) != DEPTH);
    prev = need[i];
    beat = en && (qsize(i) != 0) && (need[i] == 0);
    w    = beat ? qpop(i) : 16'h0;
    if (beat)             need[i] = gap;
    else if (need[i] > 0) need[i] = need[i] - 1;
    if (iv && rdy) qpush(i, id);
    ebv[i]   = beat;
    ebd[i]   = w;
    if (beat) mcnt[i] = mcnt[i] + 16'd1;
    ebusy[i] = beat || (prev > 0) || (qsize(i) != 0);
  endfunction

  task automatic step();
    chk("rdy0", 32'(rdy0), 32'(qsize(0) != DEPTH));
    chk("rdy2", 32'(rdy2), 32'(qsize(1) != DEPTH));
    model_edge(0, 0);
    model_edge(1, 2);
    @(posedge clk);
    @(negedge clk);
    chk("bv0", 32'(bv0), 32'(ebv[0]));
    chk("bd0", 32'(bd0), 32'(ebd[0]));
    chk("lvl0", 32'(lvl0), 32'(qsize(0)));
    chk("cnt0", 32'(cnt0), 32'(mcnt[0]));
    chk("busy0", 32'(busy0), 32'(ebusy[0]));
    chk("bv2", 32'(bv2), 32'(ebv[1]));
    chk("bd2", 32'(bd2), 32'(ebd[1]));
    chk("lvl2", 32'(lvl2), 32'(qsize(1)));
    chk("cnt2", 32'(cnt2), 32'(mcnt[1]));
    chk("busy2", 32'(busy2), 32'(ebusy[1]));
  endtask

  // called just after a falling edge; clears must be visible at once
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_bv0", 32'(bv0), 0);
    chk("rst_bd0", 32'(bd0), 0);
    chk("rst_rdy0", 32'(rdy0), 0);
    chk("rst_lvl0", 32'(lvl0), 0);
    chk("rst_cnt0", 32'(cnt0), 0);
    chk("rst_bv2", 32'(bv2), 0);
    chk("rst_lvl2", 32'(lvl2), 0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rdy0_after", 32'(rdy0), 1);
    chk("rst_rdy2_after", 32'(rdy2), 1);
  endtask

  typedef struct {
    bit          v;
    logic [15:0] d;
    bit          bv0;
    logic [15:0] bd0;
    int          c0;
    bit          bv2;
    logic [15:0] bd2;
    int          c2;
  } vec_t;

  vec_t        tbl[9];
  logic [15:0] w4[5];
  int          k, nb, acc5, beats;
  bit          acc, seen;

  initial begin
    tbl[0] = '{1'b1, 16'h1111, 1'b0, 16'h0000, 0, 1'b0, 16'h0000, 0};
    tbl[1] = '{1'b1, 16'h2222, 1'b1, 16'h1111, 1, 1'b1, 16'h1111, 1};
    tbl[2] = '{1'b1, 16'h3333, 1'b1, 16'h2222, 2, 1'b0, 16'h0000, 1};
    tbl[3] = '{1'b0, 16'h0000, 1'b1, 16'h3333, 3, 1'b0, 16'h0000, 1};
    tbl[4] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 3, 1'b1, 16'h2222, 2};
    tbl[5] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 3, 1'b0, 16'h0000, 2};
    tbl[6] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 3, 1'b0, 16'h0000, 2};
    tbl[7] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 3, 1'b1, 16'h3333, 3};
    tbl[8] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 3, 1'b0, 16'h0000, 3};
    w4[0] = 16'hA001;
    w4[1] = 16'hA002;
    w4[2] = 16'hA003;
    w4[3] = 16'hA004;
    w4[4] = 16'hA005;
    model_clear();

    @(negedge clk);
    do_reset();

    // back-to-back burst on GAP=0, spaced beats on GAP=2
    en = 1'b1;
    for (int r = 0; r < 9; r++) begin
      iv = tbl[r].v;
      id = tbl[r].d;
      step();
      chk("tbl_bv0", 32'(bv0), 32'(tbl[r].bv0));
      chk("tbl_bd0", 32'(bd0), 32'(tbl[r].bd0));
      chk("tbl_cnt0", 32'(cnt0), 32'(tbl[r].c0));
      chk("tbl_bv2", 32'(bv2), 32'(tbl[r].bv2));
      chk("tbl_bd2", 32'(bd2), 32'(tbl[r].bd2));
      chk("tbl_cnt2", 32'(cnt2), 32'(tbl[r].c2));
    end

    // fill while disabled, then drain; producer holds word until taken
    do_reset();
    en = 1'b0;
    k = 0;
    nb = 0;
    acc5 = -1;
    for (int c = 0; c < 30 && nb < 5; c++) begin
      if (c == 6) en = 1'b1;
      iv = (k < 5);
      id = (k < 5) ? w4[k] : 16'h0;
      acc = iv && rdy0;
      if (c == 4) begin
        chk("t4_lvl_full", 32'(lvl0), 4);
        chk("t4_rdy_full", 32'(rdy0), 0);
      end
      step();
      if (acc) begin
        k++;
        if (k == 5) acc5 = c;
      end
      if (bv0) begin
        chk("t4_order", 32'(bd0), 32'(w4[nb]));
        nb++;
      end
    end
    chk("t4_beats", 32'(nb), 5);
    chk("t4_5th_edge", 32'(acc5), 7);
    iv = 1'b0;

    // reset in the middle of a burst, then a fresh word goes out first
    do_reset();
    en = 1'b1;
    iv = 1'b1;
    id = 16'h1111;
    step();
    id = 16'h2222;
    step();
    chk("t5_first_bv", 32'(bv0), 1);
    chk("t5_first_bd", 32'(bd0), 32'h1111);
    do_reset();
    id = 16'hBEEF;
    step();
    iv = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      step();
      if (bv0) begin
        seen = 1'b1;
        chk("t5_beef", 32'(bd0), 32'hBEEF);
        chk("t5_cnt", 32'(cnt0), 1);
      end
    end
    if (!seen) chk("t5_timeout", 0, 1);

    // randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      en = ($urandom_range(0, 3) != 0);
      iv = ($urandom_range(0, 1) != 0);
      id = 16'($urandom);
      if ($urandom_range(0, 299) == 0) do_reset();
      step();
    end

    // sent_count wrap on the back-to-back instance
    do_reset();
    en = 1'b1;
    iv = 1'b1;
    beats = 0;
    for (int c = 0; c < 65540; c++) begin
      id = 16'($urandom);
      step();
      if (bv0) begin
        beats++;
        if (beats == 65536) chk("t6_wrap", 32'(cnt0), 0);
        if (beats == 65537) chk("t6_after_wrap", 32'(cnt0), 1);
      end
    end
    chk("t6_beats", 32'(beats >= 65537), 1);
    iv = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
